// File: rtl/nonce_arbiter_pkg.sv
// Shared hashvoodoo constants: transmit FSM encoding and default sizing
// for the nonce arbiter and its FIFO.
package nonce_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    localparam int NONCE_W          = 32;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_BUSY_TIMEOUT = 255;

endpackage

// File: rtl/nonce_fifo.sv
// Power-of-two nonce FIFO with occupancy count; head word is visible
// combinationally so the transmitter can load it on the pop cycle.
module nonce_fifo
    import nonce_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [NONCE_W-1:0]       push_data,
    input  logic                     pop,
    output logic [NONCE_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [NONCE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic               push_en, pop_en;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/nonce_arbiter.sv
// Round-robin collector of hasher nonces into a FIFO feeding a UART.
// Optional NONCE_ARB_DEDUP_EN drops pushes equal to the last transmitted nonce.
module nonce_arbiter
    import nonce_arbiter_pkg::*;
#(
    parameter int SLAVES       = 2,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SLAVES-1:0]             new_nonces,
    input  logic [NONCE_W*SLAVES-1:0]     slave_nonces,
    input  logic                          serial_busy,
    output logic                          serial_send,
    output logic [NONCE_W-1:0]            golden_nonce,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_SLAVE = PW'(SLAVES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    logic [NONCE_W-1:0] hold_q [SLAVES];
    logic [SLAVES-1:0]  older_q [SLAVES];
    logic [SLAVES-1:0]  pending_q, pending_d, clear_mask;
    logic [PW-1:0]      rr_q, rr_d, win_idx, drop_idx;
    logic               win_found, any_pending, arb_go, drop_go, is_dup;
    logic [NONCE_W-1:0] win_data, fifo_head, golden_q;
    logic               overflow_q;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    tx_state_e          state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;

    for (genvar gi = 0; gi < SLAVES; gi++) begin : g_hold
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_q[gi] <= '0;
            end else if (new_nonces[gi]) begin
                hold_q[gi] <= slave_nonces[NONCE_W*gi +: NONCE_W];
            end
        end
    end

    // older_q[i][j]: slave i's held nonce arrived before slave j's.
    // A fresh strobe makes that slave the youngest; same-cycle ties go to the lower index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLAVES; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                for (int j = 0; j < SLAVES; j++) begin
                    if (new_nonces[i] && new_nonces[j]) older_q[i][j] <= (i < j);
                    else if (new_nonces[i])             older_q[i][j] <= 1'b0;
                    else if (new_nonces[j])             older_q[i][j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (!win_found && pending_q[i] && (i >= int'(rr_q))) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int i = 0; i < SLAVES; i++) begin
            if (!win_found && pending_q[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        logic is_old;
        is_old   = 1'b0;
        drop_idx = '0;
        for (int i = 0; i < SLAVES; i++) begin
            is_old = pending_q[i];
            for (int j = 0; j < SLAVES; j++) begin
                if ((j != i) && pending_q[j] && !older_q[i][j]) is_old = 1'b0;
            end
            if (is_old) drop_idx = PW'(i);
        end
    end

    assign any_pending = |pending_q;
    assign arb_go      = any_pending && !fifo_full;
    assign drop_go     = any_pending && fifo_full;
    assign win_data    = hold_q[win_idx];
    assign rr_d        = (win_idx == LAST_SLAVE) ? '0 : win_idx + 1'b1;

`ifdef NONCE_ARB_DEDUP_EN
    logic last_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      last_valid_q <= 1'b0;
        else if (fifo_pop) last_valid_q <= 1'b1;
    end

    assign is_dup = last_valid_q && (win_data == golden_q);
`else
    assign is_dup = 1'b0;
`endif

    // A suppressed duplicate still counts as arbitrated: pending clears and rr advances.
    assign fifo_push = arb_go && !is_dup;

    always_comb begin
        clear_mask = '0;
        if (arb_go)  clear_mask[win_idx]  = 1'b1;
        if (drop_go) clear_mask[drop_idx] = 1'b1;
        pending_d = (pending_q & ~clear_mask) | new_nonces;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (arb_go)  rr_q       <= rr_d;
            if (drop_go) overflow_q <= 1'b1;
        end
    end

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (win_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fifo_pop    = 1'b0;
        serial_send = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !serial_busy) begin
                    fifo_pop = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                serial_send = 1'b1;
                timer_d     = '0;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (serial_busy)                state_d = WAIT_DONE;
                else if (timer_q == TIMER_LAST) state_d = IDLE;
                else                            timer_d = timer_q + 1'b1;
            end
            WAIT_DONE: begin
                if (!serial_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            golden_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (fifo_pop) golden_q <= fifo_head;
        end
    end

    assign golden_nonce = golden_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// Directed self-checking bench for nonce_arbiter (SLAVES=2, depth 4, timeout 255)
// with a simple UART busy model and a log of every transmitted nonce.
module tb_nonce_arbiter;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b1;
    logic [1:0]  new_nonces   = '0;
    logic [63:0] slave_nonces = '0;
    logic        serial_busy;
    logic        serial_send;
    logic [31:0] golden_nonce;
    logic        overflow;
    logic [2:0]  fifo_level;

    logic        busy_force = 1'b0;
    logic        uart_en    = 1'b0;
    int          ucnt       = 0;
    logic [31:0] sent_q [$];
    int          checks     = 0;
    int          errors     = 0;
    int          exp_sends;

    nonce_arbiter #(
        .SLAVES       (2),
        .FIFO_DEPTH   (4),
        .BUSY_TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_nonces   (new_nonces),
        .slave_nonces (slave_nonces),
        .serial_busy  (serial_busy),
        .serial_send  (serial_send),
        .golden_nonce (golden_nonce),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles after each send when enabled.
    assign serial_busy = busy_force | (ucnt != 0);

    always @(posedge clk) begin
        if (serial_send && uart_en) ucnt <= 10;
        else if (ucnt != 0)         ucnt <= ucnt - 1;
        if (serial_send) begin
            sent_q.push_back(golden_nonce);
            $display("tx: serial_send golden_nonce=0x%08h at %0t", golden_nonce, $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        new_nonces = '0;
        busy_force = 1'b0;
        uart_en    = 1'b0;
        tick(12);
        sent_q.delete();
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic strobe(input logic [1:0] m, input logic [31:0] v0, input logic [31:0] v1);
        new_nonces   = m;
        slave_nonces = {v1, v0};
        tick(1);
        new_nonces   = '0;
    endtask

    initial begin
        // Reset state, sampled while reset_n is held low.
        #1 reset_n = 1'b0;
        #1;
        check("rst_send",     {31'd0, serial_send}, 32'd0);
        check("rst_golden",   golden_nonce,         32'd0);
        check("rst_overflow", {31'd0, overflow},    32'd0);
        check("rst_level",    {29'd0, fifo_level},  32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Simultaneous strobes: slave0 first, push/pop overlap keeps level at 1.
        uart_en = 1'b1;
        strobe(2'b11, 32'h11111111, 32'h22222222);
        check("t1_level_latch", {29'd0, fifo_level}, 32'd0);
        tick(1);
        check("t1_level_push0", {29'd0, fifo_level}, 32'd1);
        tick(1);
        check("t1_level_pushpop", {29'd0, fifo_level}, 32'd1);
        check("t1_send_high",     {31'd0, serial_send}, 32'd1);
        check("t1_golden0",       golden_nonce, 32'h11111111);
        tick(1);
        check("t1_send_pulse",    {31'd0, serial_send}, 32'd0);
        tick(60);
        check("t1_num_sent", 32'(sent_q.size()), 32'd2);
        check("t1_sent0",    sent_q[0], 32'h11111111);
        check("t1_sent1",    sent_q[1], 32'h22222222);
        check("t1_overflow", {31'd0, overflow}, 32'd0);

        // Five nonces into a depth-4 FIFO while the UART is busy.
        do_reset();
        busy_force = 1'b1;
        for (int k = 0; k < 5; k++) strobe(2'b01, 32'hA0 + k, 32'd0);
        tick(8);
        check("t2_level_full", {29'd0, fifo_level}, 32'd4);
        check("t2_overflow",   {31'd0, overflow},   32'd1);
        check("t2_no_send",    32'(sent_q.size()),  32'd0);
        busy_force = 1'b0;
        uart_en    = 1'b1;
        tick(100);
        check("t2_num_sent", 32'(sent_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t2_sent%0d", k), sent_q[k], 32'hA0 + k);
        check("t2_overflow_sticky", {31'd0, overflow},  32'd1);
        check("t2_level_empty",     {29'd0, fifo_level}, 32'd0);

        // serial_busy never rises: 255-cycle timeout before the next send.
        do_reset();
        strobe(2'b11, 32'hDEADBEEF, 32'h0BADF00D);
        tick(2);
        check("t3_send_first", {31'd0, serial_send}, 32'd1);
        check("t3_golden0",    golden_nonce, 32'hDEADBEEF);
        tick(256);
        check("t3_no_send_before_timeout", {31'd0, serial_send}, 32'd0);
        check("t3_level_waiting",          {29'd0, fifo_level},  32'd1);
        tick(1);
        check("t3_send_after_timeout", {31'd0, serial_send}, 32'd1);
        check("t3_golden1",            golden_nonce, 32'h0BADF00D);
        tick(300);
        check("t3_num_sent", 32'(sent_q.size()), 32'd2);
        check("t3_sent0",    sent_q[0], 32'hDEADBEEF);
        check("t3_level",    {29'd0, fifo_level}, 32'd0);

        // Reset while in WAIT_DONE with three nonces queued.
        do_reset();
        for (int k = 0; k < 4; k++) strobe(2'b01, 32'hC0 + k, 32'd0);
        busy_force = 1'b1;
        tick(3);
        check("t4_level_queued", {29'd0, fifo_level}, 32'd3);
        check("t4_num_sent_pre", 32'(sent_q.size()), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t4_rst_send",     {31'd0, serial_send}, 32'd0);
        check("t4_rst_golden",   golden_nonce,         32'd0);
        check("t4_rst_overflow", {31'd0, overflow},    32'd0);
        check("t4_rst_level",    {29'd0, fifo_level},  32'd0);
        tick(2);
        reset_n    = 1'b1;
        busy_force = 1'b0;
        uart_en    = 1'b1;
        tick(1);
        check("t4_send_after_release", {31'd0, serial_send}, 32'd0);
        tick(50);
        check("t4_num_sent_post", 32'(sent_q.size()), 32'd1);

        // Same nonce twice, 50 cycles apart.
        do_reset();
        uart_en = 1'b1;
        strobe(2'b01, 32'h12345678, 32'd0);
        tick(50);
        strobe(2'b01, 32'h12345678, 32'd0);
        tick(60);
`ifdef NONCE_ARB_DEDUP_EN
        exp_sends = 1;
`else
        exp_sends = 2;
`endif
        check("t5_dup_sends", 32'(sent_q.size()), 32'(exp_sends));

        // Slave0 strobes every cycle; slave1's single nonce must not starve.
        do_reset();
        busy_force = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            new_nonces   = (k == 2) ? 2'b11 : 2'b01;
            slave_nonces = {32'h000000B1, 32'h50 + k};
            tick(1);
            if (k == 3) check("t6_level_after_slave1", {29'd0, fifo_level}, 32'd2);
        end
        new_nonces = '0;
        tick(1);
        check("t6_level_full", {29'd0, fifo_level}, 32'd4);
        check("t6_overflow",   {31'd0, overflow},   32'd0);
        busy_force = 1'b0;
        uart_en    = 1'b1;
        tick(100);
        check("t6_num_sent", 32'(sent_q.size()), 32'd4);
        check("t6_sent0",    sent_q[0], 32'h00000051);
        check("t6_sent1",    sent_q[1], 32'h000000B1);
        check("t6_sent2",    sent_q[2], 32'h00000053);
        check("t6_sent3",    sent_q[3], 32'h00000054);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nonce_arbiter.md
NONCE_ARBITER -- requirements
Module: nonce_arbiter

Interface
REQ-001 SHALL have parameter SLAVES, default 2, number of hasher cores feeding nonces (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, queued nonces awaiting transmit (power of 2, 2..16).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 255, clk cycles allowed for serial_busy to assert after serial_send.
REQ-004 clk  input  1  comm clock; sole clock, all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 new_nonces  input  SLAVES  per-slave one-cycle strobe: the nonce on slave_nonces is valid.
REQ-007 slave_nonces  input  32*SLAVES  slave i nonce in bits [32i+31:32i].
REQ-008 serial_busy  input  1  UART transmitter busy.
REQ-009 serial_send  output  1  one-cycle strobe starting a UART transmit of golden_nonce.
REQ-010 golden_nonce  output  32  nonce presented to UART; held stable from serial_send until serial_busy falls.
REQ-011 overflow  output  1  sticky; a nonce was dropped on a full FIFO.
REQ-012 fifo_level  output  clog2(FIFO_DEPTH)+1  current queued count.

Function
REQ-013 Each new_nonces[i] strobe SHALL set pending[i] and latch slave_nonces[i] into a per-slave holding register in the same cycle.
REQ-014 A strobe arriving while pending[i] is already set SHALL overwrite the holding register (newest wins) without setting overflow.
REQ-015 Arbitration SHALL be round-robin: each cycle, when the FIFO is not full, the first pending slave at or after rr_ptr is pushed, its pending bit cleared, rr_ptr set to winner+1 mod SLAVES.
REQ-016 Strobe-to-push latency SHALL be 1 cycle with no contention; worst case SLAVES cycles.
REQ-017 When the FIFO is full and any slave is pending, the oldest pending holding value SHALL be dropped, overflow set, pending bit cleared.
REQ-018 Transmit FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> SEND when FIFO non-empty and serial_busy low; the FIFO head is popped into golden_nonce.
REQ-020 SEND SHALL assert serial_send for exactly one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE on serial_busy high; -> IDLE after BUSY_TIMEOUT cycles without it (nonce treated as sent).
REQ-022 WAIT_DONE -> IDLE on serial_busy low.
REQ-023 Simultaneous push and pop SHALL both occur; fifo_level unchanged.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full = level==FIFO_DEPTH, empty = level==0.
REQ-025 overflow SHALL clear only on reset.

Reset
REQ-026 On reset_n low, immediately: serial_send=0, golden_nonce=0, overflow=0, fifo_level=0, pending=0, rr_ptr=0, FSM=IDLE, timeout counter=0.
REQ-027 Reset mid-transmit SHALL discard all queued and pending nonces; no serial_send for 1 cycle after reset_n rises.

Configuration
REQ-028 Macro NONCE_ARB_DEDUP_EN, when defined, SHALL suppress a push whose value equals the last value loaded into golden_nonce since reset (the pending bit is still cleared).
REQ-029 Without NONCE_ARB_DEDUP_EN every arbitrated nonce SHALL be queued, duplicates included.

Structure
REQ-030 FSM state encodings, default FIFO_DEPTH and BUSY_TIMEOUT SHALL live in the shared hashvoodoo constants package.
REQ-031 The FIFO SHALL be a sub-module nonce_fifo (synchronous, 32-bit, push/pop/level, clk, reset_n).

Verification
REQ-032 SLAVES=2; slave0 strobes 0x11111111, slave1 strobes 0x22222222 in the same cycle; UART busy 10 cycles per send -> sends 0x11111111 then 0x22222222, one serial_send pulse each.
REQ-033 5 nonces 0xA0..0xA4 with serial_busy held high -> 4 queued, fifo_level=4, overflow=1, only 0xA0..0xA3 sent after busy falls.
REQ-034 One nonce 0xDEADBEEF, serial_busy never asserts -> serial_send once, FSM back in IDLE after 256 cycles, fifo_level=0.
REQ-035 reset_n pulsed low during WAIT_DONE with 3 queued -> all outputs 0, no further serial_send.
REQ-036 NONCE_ARB_DEDUP_EN defined; 0x12345678 strobed twice 50 cycles apart -> exactly one serial_send; undefined -> two.
REQ-037 Slave0 strobes every cycle while slave1 strobes once -> slave1 nonce pushed within 2 cycles (no starvation).
